// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ID/EX operand stage signal bundle
// Purpose: groups the decode-side inputs, the forwarding inputs and the EX-side
// outputs of ex_operand_stage into one interface.
// Modports:
//   master - drives id_*, flush, hold, forward_*, mem_alu_result, wb_result;
//            observes ex_*, stall_if_id, perf_loaduse_cnt
//   slave  - the stage itself (mirror of master)
interface ex_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RW   = 5
);
    logic            id_valid;
    logic [RW-1:0]   id_rs1;
    logic [RW-1:0]   id_rs2;
    logic [RW-1:0]   id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alusrc;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic            flush;
    logic            hold;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] wb_result;
    logic            ex_valid;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_alusrc;
    logic [RW-1:0]   ex_rs1;
    logic [RW-1:0]   ex_rs2;
    logic [RW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_op_a;
    logic [XLEN-1:0] ex_op_b;
    logic [XLEN-1:0] ex_store_data;
    logic            stall_if_id;
    logic [31:0]     perf_loaduse_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
        output id_alusrc, id_regwrite, id_memread, id_memwrite,
        output flush, hold, forward_a, forward_b, mem_alu_result, wb_result,
        input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc,
        input  ex_rs1, ex_rs2, ex_rd, ex_op_a, ex_op_b, ex_store_data,
        input  stall_if_id, perf_loaduse_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
        input  id_alusrc, id_regwrite, id_memread, id_memwrite,
        input  flush, hold, forward_a, forward_b, mem_alu_result, wb_result,
        output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc,
        output ex_rs1, ex_rs2, ex_rd, ex_op_a, ex_op_b, ex_store_data,
        output stall_if_id, perf_loaduse_cnt
    );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with load-use bubble and operand forwarding mux
// Purpose: captures the decoded ID instruction, inserts a single bubble on a
// load-use hazard (stalling IF/ID), and builds ALU operands / store data from
// the registered EX state and the two-bit forwarding selects.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - ex_operand_stage_if.slave (ID inputs, flush/hold, forwarding
//           selects and sources, EX outputs, stall_if_id, perf_loaduse_cnt)
// Optional feature: EX_LOADUSE_PERF_EN enables the 32-bit load-use bubble
// counter; when undefined perf_loaduse_cnt is tied to 0.
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input logic              clk,
    input logic              reset,
    ex_operand_stage_if.slave bus
);
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            lu;
    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;

    // A load in EX whose destination is read by the ID instruction cannot be
    // forwarded in time; x0 never creates a dependency.
    assign lu = bus.ex_valid & bus.ex_memread & (bus.ex_rd != '0) & bus.id_valid &
                ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

    // A redirect kills the ID instruction anyway, so there is nothing to hold.
    assign bus.stall_if_id = ~bus.flush & (bus.hold | lu);

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_regwrite <= 1'b0;
            bus.ex_memread  <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_alusrc   <= 1'b0;
            bus.ex_rs1      <= '0;
            bus.ex_rs2      <= '0;
            bus.ex_rd       <= '0;
            rs1_data        <= '0;
            rs2_data        <= '0;
            imm             <= '0;
        end else if (bus.hold) begin
            // frozen: every register keeps its value
        end else if (lu) begin
            // Bubble: only control and rd matter; operands are left as they are.
            bus.ex_valid    <= 1'b0;
            bus.ex_regwrite <= 1'b0;
            bus.ex_memread  <= 1'b0;
            bus.ex_memwrite <= 1'b0;
            bus.ex_alusrc   <= 1'b0;
            bus.ex_rd       <= '0;
        end else begin
            bus.ex_valid    <= bus.id_valid;
            bus.ex_regwrite <= bus.id_regwrite;
            bus.ex_memread  <= bus.id_memread;
            bus.ex_memwrite <= bus.id_memwrite;
            bus.ex_alusrc   <= bus.id_alusrc;
            bus.ex_rs1      <= bus.id_rs1;
            bus.ex_rs2      <= bus.id_rs2;
            bus.ex_rd       <= bus.id_rd;
            rs1_data        <= bus.id_rs1_data;
            rs2_data        <= bus.id_rs2_data;
            imm             <= bus.id_imm;
        end
    end

    // Reserved code 11 and any reference to x0 fall back to the register value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      code,
        input logic [RW-1:0]   idx,
        input logic [XLEN-1:0] regv,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] wb
    );
        logic [XLEN-1:0] r;
        r = regv;
        if (idx != '0) begin
            if (code == 2'b01)      r = mem;
            else if (code == 2'b10) r = wb;
        end
        return r;
    endfunction

    assign fa = fwd_sel(bus.forward_a, bus.ex_rs1, rs1_data, bus.mem_alu_result, bus.wb_result);
    assign fb = fwd_sel(bus.forward_b, bus.ex_rs2, rs2_data, bus.mem_alu_result, bus.wb_result);

    assign bus.ex_op_a       = fa;
    assign bus.ex_op_b       = bus.ex_alusrc ? imm : fb;
    assign bus.ex_store_data = fb;

`ifdef EX_LOADUSE_PERF_EN
    logic [31:0] lu_cnt;

    // Counts only edges where the bubble is actually inserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            lu_cnt <= '0;
        end else if (!bus.flush && !bus.hold && lu) begin
            lu_cnt <= lu_cnt + 32'd1;
        end
    end

    assign bus.perf_loaduse_cnt = lu_cnt;
`else
    assign bus.perf_loaduse_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - self-checking bench for ex_operand_stage
module tb_ex_operand_stage;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    ex_operand_stage_if #(.XLEN(32), .RW(5)) bus ();

    ex_operand_stage #(.XLEN(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef EX_LOADUSE_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        bit          valid;
        bit          regwrite;
        bit          memread;
        bit          memwrite;
        bit          alusrc;
        int unsigned rs1;
        int unsigned rs2;
        int unsigned rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        bit          known;   // operands/indices are defined (not left over from a bubble)
    } ex_instr_t;

    ex_instr_t   m;
    logic [31:0] m_cnt;

    function automatic bit model_lu();
        return m.valid && m.memread && m.rd != 0 && bus.id_valid &&
               (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
    endfunction

    function automatic logic [31:0] pick(int unsigned code, int unsigned idx, logic [31:0] regv);
        if (idx == 0) return regv;
        if (code == 1) return bus.mem_alu_result;
        if (code == 2) return bus.wb_result;
        return regv;
    endfunction

    task automatic clear_model();
        m = '{valid: 0, regwrite: 0, memread: 0, memwrite: 0, alusrc: 0,
              rs1: 0, rs2: 0, rd: 0, d1: 0, d2: 0, imm: 0, known: 1};
    endtask

    task automatic model_update();
        bit lu;
        lu = model_lu();
        if (reset) begin
            clear_model();
            m_cnt = 0;
        end else if (bus.flush) begin
            clear_model();
        end else if (bus.hold) begin
        end else if (lu) begin
            m.valid = 0; m.regwrite = 0; m.memread = 0; m.memwrite = 0; m.alusrc = 0;
            m.rd = 0; m.known = 0;
            m_cnt = m_cnt + 1;
        end else begin
            m = '{valid: bus.id_valid, regwrite: bus.id_regwrite, memread: bus.id_memread,
                  memwrite: bus.id_memwrite, alusrc: bus.id_alusrc,
                  rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                  d1: bus.id_rs1_data, d2: bus.id_rs2_data, imm: bus.id_imm, known: 1};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [31:0] fa;
        logic [31:0] fb;
        chk("stall_if_id", bus.stall_if_id, 32'(!bus.flush && (bus.hold || model_lu())));
        chk("ex_valid", bus.ex_valid, 32'(m.valid));
        chk("ex_regwrite", bus.ex_regwrite, 32'(m.regwrite));
        chk("ex_memread", bus.ex_memread, 32'(m.memread));
        chk("ex_memwrite", bus.ex_memwrite, 32'(m.memwrite));
        chk("ex_alusrc", bus.ex_alusrc, 32'(m.alusrc));
        chk("ex_rd", bus.ex_rd, m.rd);
        chk("perf_loaduse_cnt", bus.perf_loaduse_cnt, PERF_EN ? m_cnt : 32'd0);
        if (m.known) begin
            fa = pick(bus.forward_a, m.rs1, m.d1);
            fb = pick(bus.forward_b, m.rs2, m.d2);
            chk("ex_rs1", bus.ex_rs1, m.rs1);
            chk("ex_rs2", bus.ex_rs2, m.rs2);
            chk("ex_op_a", bus.ex_op_a, fa);
            chk("ex_op_b", bus.ex_op_b, m.alusrc ? m.imm : fb);
            chk("ex_store_data", bus.ex_store_data, fb);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle_and_compare();
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        reset = 0;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
        bus.id_alusrc = 0; bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0;
        bus.flush = 0; bus.hold = 0; bus.forward_a = 0; bus.forward_b = 0;
        bus.mem_alu_result = 0; bus.wb_result = 0;
    endtask

    task automatic set_id(input int unsigned rs1, input int unsigned rs2, input int unsigned rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input bit alusrc, input bit regwrite, input bit memread, input bit memwrite);
        bus.id_valid = 1;
        bus.id_rs1 = 5'(rs1); bus.id_rs2 = 5'(rs2); bus.id_rd = 5'(rd);
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_alusrc = alusrc; bus.id_regwrite = regwrite;
        bus.id_memread = memread; bus.id_memwrite = memwrite;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_cnt = 0;
        clear_model();
        set_idle();
        reset = 1;
        tick();
        tick();

        // reset state
        set_idle();
        settle_and_compare();
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_stall", bus.stall_if_id, 0);
        chk("rst_perf", bus.perf_loaduse_cnt, 0);
        chk("rst_op_a", bus.ex_op_a, 0);

        // plain capture with immediate operand
        set_id(1, 2, 5, 32'h11, 32'h22, 32'h10, 1, 1, 0, 0);
        settle_and_compare();
        tick();
        set_idle();
        settle_and_compare();
        chk("plain_valid", bus.ex_valid, 1);
        chk("plain_rd", bus.ex_rd, 5);
        chk("plain_op_b", bus.ex_op_b, 32'h10);
        chk("plain_stall", bus.stall_if_id, 0);

        // forwarding from MEM and WB
        set_id(3, 4, 6, 32'h1111, 32'h2222, 32'h99, 0, 1, 0, 0);
        tick();
        set_idle();
        bus.forward_a = 2'b01; bus.forward_b = 2'b10;
        bus.mem_alu_result = 32'hAAAA; bus.wb_result = 32'h5555;
        settle_and_compare();
        chk("fwd_op_a", bus.ex_op_a, 32'hAAAA);
        chk("fwd_op_b", bus.ex_op_b, 32'h5555);
        chk("fwd_store", bus.ex_store_data, 32'h5555);

        // x0 is never forwarded
        set_id(0, 2, 6, 32'h0, 32'h3, 32'h0, 0, 1, 0, 0);
        tick();
        set_idle();
        bus.forward_a = 2'b01; bus.mem_alu_result = 32'hDEAD;
        settle_and_compare();
        chk("x0_op_a", bus.ex_op_a, 0);

        // load-use: lw x7 then add x8, x7, x1
        set_idle();
        set_id(2, 0, 7, 32'h100, 32'h0, 32'h4, 1, 1, 1, 0);
        tick();
        set_id(7, 1, 8, 32'h0, 32'h1, 32'h0, 0, 1, 0, 0);
        settle_and_compare();
        chk("lu_stall", bus.stall_if_id, 1);
        tick();
        settle_and_compare();
        chk("lu_bubble_valid", bus.ex_valid, 0);
        chk("lu_bubble_stall", bus.stall_if_id, 0);
        chk("lu_perf", bus.perf_loaduse_cnt, PERF_EN ? 32'd1 : 32'd0);
        tick();
        set_idle();
        settle_and_compare();
        chk("lu_dep_valid", bus.ex_valid, 1);
        chk("lu_dep_rd", bus.ex_rd, 8);

        // flush together with load-use
        set_id(2, 0, 7, 32'h100, 32'h0, 32'h4, 1, 1, 1, 0);
        tick();
        set_id(1, 7, 8, 32'h0, 32'h1, 32'h0, 0, 1, 0, 0);
        bus.flush = 1;
        settle_and_compare();
        chk("flush_lu_stall", bus.stall_if_id, 0);
        tick();
        set_idle();
        settle_and_compare();
        chk("flush_lu_valid", bus.ex_valid, 0);
        chk("flush_lu_perf", bus.perf_loaduse_cnt, PERF_EN ? 32'd1 : 32'd0);

        // hold for three cycles
        set_id(1, 2, 9, 32'h7, 32'h8, 32'h0, 0, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_id(3, 3, 12, 32'hF, 32'hF, 32'hF, 1, 0, 1, 1);
            bus.hold = 1;
            settle_and_compare();
            chk("hold_stall", bus.stall_if_id, 1);
            tick();
            chk("hold_rd", bus.ex_rd, 9);
            chk("hold_valid", bus.ex_valid, 1);
        end
        set_idle();
        settle_and_compare();

        // reset during a load-use stall
        set_id(2, 0, 7, 32'h100, 32'h0, 32'h4, 1, 1, 1, 0);
        tick();
        set_id(7, 7, 8, 32'h0, 32'h1, 32'h0, 0, 1, 0, 0);
        settle_and_compare();
        chk("rst_mid_stall_pre", bus.stall_if_id, 1);
        reset = 1;
        tick();
        set_idle();
        settle_and_compare();
        chk("rst_mid_valid", bus.ex_valid, 0);
        chk("rst_mid_stall", bus.stall_if_id, 0);
        chk("rst_mid_rd", bus.ex_rd, 0);
        chk("rst_mid_perf", bus.perf_loaduse_cnt, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_idle();
            reset = ($urandom_range(0, 99) < 2);
            bus.flush = ($urandom_range(0, 99) < 8);
            bus.hold = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 99) < 85) begin
                set_id($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom, $urandom, $urandom,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 99) < 40), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 99) < 30) bus.id_rs1 = 5'(m.rd);
                if ($urandom_range(0, 99) < 15) bus.id_rs2 = 5'(m.rd);
            end
            bus.forward_a = 2'($urandom_range(0, 3));
            bus.forward_b = 2'($urandom_range(0, 3));
            bus.mem_alu_result = $urandom;
            bus.wb_result = $urandom;
            settle_and_compare();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
